// File: rtl/snitch_ssr_credit_pool.sv
// snitch_ssr_credit_pool
//   Multi-channel credit pool for SSR data movers. Each channel keeps an
//   independent credit count. Every cycle a channel can be given and/or
//   charged a variable number of credits. Counts saturate at 0 and
//   NumCredits, and any over/underflow sets a sticky per-channel error flag.
//
// Ports
//   clk_i              clock, all state updates on the rising edge
//   rst_i              synchronous active-high reset
//   init_i             per-channel soft reinit to cfg_init_credits_i (clamped)
//   cfg_init_credits_i reinit value shared by all channels
//   give_i/give_amt_i  per-channel give strobe and amount (StepW bits each)
//   take_i/take_amt_i  per-channel take strobe and amount (StepW bits each)
//   err_clr_i          per-channel clear of the sticky error flag
//   credit_o           current count per channel (CntW bits each, registered)
//   credit_left_o      count != 0
//   credit_crit_o      count > NumCredits-MaxStep (a max-size give would overflow)
//   credit_full_o      count == NumCredits
//   err_o              sticky over/underflow flag
//
// All status outputs are decoded from the registered count only, so no
// combinational path runs from any input to any output.

module snitch_ssr_credit_pool #(
  parameter int unsigned NumChannels     = 2,
  parameter int unsigned NumCredits      = 8,
  parameter int unsigned MaxStep         = 4,
  parameter bit          InitCreditEmpty = 1'b0,
  // Turns a saturation event into a simulation assertion failure. Off by
  // default because err_o is the normal way saturation is reported.
  parameter bit          StrictCredit    = 1'b0,
  localparam int unsigned CntW           = $clog2(NumCredits + 1),
  localparam int unsigned StepW          = $clog2(MaxStep + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NumChannels-1:0]       init_i,
  input  logic [CntW-1:0]              cfg_init_credits_i,
  input  logic [NumChannels-1:0]       give_i,
  input  logic [NumChannels*StepW-1:0] give_amt_i,
  input  logic [NumChannels-1:0]       take_i,
  input  logic [NumChannels*StepW-1:0] take_amt_i,
  input  logic [NumChannels-1:0]       err_clr_i,
  output logic [NumChannels*CntW-1:0]  credit_o,
  output logic [NumChannels-1:0]       credit_left_o,
  output logic [NumChannels-1:0]       credit_crit_o,
  output logic [NumChannels-1:0]       credit_full_o,
  output logic [NumChannels-1:0]       err_o
);

  // Two extra bits hold a sign and the carry of q+g. This keeps the signed
  // range wide enough for both -MaxStep and 2*NumCredits.
  localparam int unsigned ExtW = CntW + 2;

  localparam logic [CntW-1:0]  MaxCnt   = CntW'(NumCredits);
  localparam logic [CntW-1:0]  CritCnt  = CntW'(NumCredits - MaxStep);
  localparam logic [CntW-1:0]  ResetCnt = InitCreditEmpty ? '0 : CntW'(NumCredits);
  localparam logic [StepW-1:0] MaxAmt   = StepW'(MaxStep);
  localparam logic [ExtW-1:0]  MaxCntX  = ExtW'(NumCredits);

  // Reinit value clamped to capacity. It is shared, so it is computed once.
  logic [CntW-1:0] w_init_val;

  always_comb begin
    w_init_val = cfg_init_credits_i;
    if (cfg_init_credits_i > MaxCnt) begin
      w_init_val = MaxCnt;
    end
  end

  for (genvar c = 0; c < NumChannels; c++) begin : g_ch
    logic [CntW-1:0]  r_cnt;
    logic             r_err;
    logic [StepW-1:0] w_give_raw;
    logic [StepW-1:0] w_take_raw;
    logic [StepW-1:0] w_give;
    logic [StepW-1:0] w_take;
    logic [ExtW-1:0]  w_sum;
    logic             w_under;
    logic             w_over;
    logic [CntW-1:0]  w_cnt_d;
    logic             w_err_d;

    assign w_give_raw = give_amt_i[c*StepW +: StepW];
    assign w_take_raw = take_amt_i[c*StepW +: StepW];

    // Gate the amounts with their strobes and clamp them to MaxStep.
    always_comb begin
      w_give = '0;
      w_take = '0;
      if (give_i[c]) begin
        w_give = (w_give_raw > MaxAmt) ? MaxAmt : w_give_raw;
      end
      if (take_i[c]) begin
        w_take = (w_take_raw > MaxAmt) ? MaxAmt : w_take_raw;
      end
    end

    // Net update in two's complement. The MSB acts as the sign bit, because
    // q+g never reaches 2^(ExtW-1).
    always_comb begin
      w_sum   = ExtW'(r_cnt) + ExtW'(w_give) - ExtW'(w_take);
      w_under = w_sum[ExtW-1];
      w_over  = !w_sum[ExtW-1] && (w_sum > MaxCntX);
    end

    // Next count and error. Init wins over strobes and leaves the error
    // untouched, although a clear in the same cycle still takes effect.
    always_comb begin
      w_cnt_d = r_cnt;
      w_err_d = r_err & ~err_clr_i[c];
      if (init_i[c]) begin
        w_cnt_d = w_init_val;
      end else if (w_under) begin
        w_cnt_d = '0;
        w_err_d = 1'b1;
      end else if (w_over) begin
        w_cnt_d = MaxCnt;
        w_err_d = 1'b1;
      end else begin
        w_cnt_d = w_sum[CntW-1:0];
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_cnt <= ResetCnt;
        r_err <= 1'b0;
      end else begin
        r_cnt <= w_cnt_d;
        r_err <= w_err_d;
      end
    end

    assign credit_o[c*CntW +: CntW] = r_cnt;
    assign credit_left_o[c]         = (r_cnt != '0);
    assign credit_crit_o[c]         = (r_cnt > CritCnt);
    assign credit_full_o[c]         = (r_cnt == MaxCnt);
    assign err_o[c]                 = r_err;

`ifndef SYNTHESIS
    a_give_amt: assert property (@(posedge clk_i) disable iff (rst_i)
      give_i[c] |-> (w_give_raw <= MaxAmt))
      else $error("give amount above MaxStep on channel %0d", c);

    a_take_amt: assert property (@(posedge clk_i) disable iff (rst_i)
      take_i[c] |-> (w_take_raw <= MaxAmt))
      else $error("take amount above MaxStep on channel %0d", c);

    if (StrictCredit) begin : g_strict
      a_no_sat: assert property (@(posedge clk_i) disable iff (rst_i)
        !init_i[c] |-> !(w_under || w_over))
        else $error("credit over/underflow on channel %0d", c);
    end
`endif
  end

`ifndef SYNTHESIS
  a_cfg: assert property (@(posedge clk_i)
    (MaxStep >= 1) && (MaxStep <= NumCredits) && (NumChannels >= 1))
    else $error("illegal credit pool parameters");
`endif

endmodule

// File: tb/tb_snitch_ssr_credit_pool.sv
// Scoreboard bench for snitch_ssr_credit_pool (2 channels, 8 credits, step 4).
// The stimulus side drives each cycle and pushes the reference model's
// expected post-edge state into a queue. A monitor on the falling edge pops
// one entry and compares it with the DUT outputs.

module tb_snitch_ssr_credit_pool;

  localparam int NCH = 2;
  localparam int NCR = 8;
  localparam int MXS = 4;
  localparam int CW  = 4;
  localparam int SW  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    init;
  logic [CW-1:0]     cfg;
  logic [NCH-1:0]    give;
  logic [NCH*SW-1:0] give_amt;
  logic [NCH-1:0]    take;
  logic [NCH*SW-1:0] take_amt;
  logic [NCH-1:0]    clr;
  logic [NCH*CW-1:0] credit;
  logic [NCH-1:0]    left;
  logic [NCH-1:0]    crit;
  logic [NCH-1:0]    full;
  logic [NCH-1:0]    err;

  snitch_ssr_credit_pool #(
    .NumChannels(NCH), .NumCredits(NCR), .MaxStep(MXS), .InitCreditEmpty(1'b0)
  ) dut (
    .clk_i(clk), .rst_i(rst), .init_i(init), .cfg_init_credits_i(cfg),
    .give_i(give), .give_amt_i(give_amt), .take_i(take), .take_amt_i(take_amt),
    .err_clr_i(clr), .credit_o(credit), .credit_left_o(left),
    .credit_crit_o(crit), .credit_full_o(full), .err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NCH*CW-1:0] credit;
    logic [NCH-1:0]    left;
    logic [NCH-1:0]    crit;
    logic [NCH-1:0]    full;
    logic [NCH-1:0]    err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: plain integer credits and flags.
  int m_cnt[NCH];
  bit m_err[NCH];

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
  endtask

  // One cycle of stimulus. Inputs are driven just after the falling edge, and
  // the model state that the next rising edge should produce is queued.
  task automatic step(input bit r, input bit [1:0] in, input int cf,
                      input bit [1:0] gv, input int g0, input int g1,
                      input bit [1:0] tk, input int t0, input int t1,
                      input bit [1:0] cl);
    int   ga[NCH];
    int   ta[NCH];
    exp_t e;
    @(negedge clk);
    #1;
    rst      = r;
    init     = in;
    cfg      = CW'(cf);
    give     = gv;
    give_amt = {SW'(g1), SW'(g0)};
    take     = tk;
    take_amt = {SW'(t1), SW'(t0)};
    clr      = cl;
    ga[0] = g0; ga[1] = g1; ta[0] = t0; ta[1] = t1;
    for (int c = 0; c < NCH; c++) begin
      if (r) begin
        m_cnt[c] = NCR;
        m_err[c] = 1'b0;
      end else if (in[c]) begin
        m_cnt[c] = (cf > NCR) ? NCR : cf;
        if (cl[c]) m_err[c] = 1'b0;
      end else begin
        int n;
        n = m_cnt[c] + (gv[c] ? ((ga[c] > MXS) ? MXS : ga[c]) : 0)
                     - (tk[c] ? ((ta[c] > MXS) ? MXS : ta[c]) : 0);
        if (cl[c]) m_err[c] = 1'b0;
        if (n < 0) begin
          m_cnt[c] = 0;
          m_err[c] = 1'b1;
        end else if (n > NCR) begin
          m_cnt[c] = NCR;
          m_err[c] = 1'b1;
        end else begin
          m_cnt[c] = n;
        end
      end
    end
    for (int c = 0; c < NCH; c++) begin
      e.credit[c*CW +: CW] = CW'(m_cnt[c]);
      e.left[c] = (m_cnt[c] != 0);
      e.crit[c] = (m_cnt[c] > NCR - MXS);
      e.full[c] = (m_cnt[c] == NCR);
      e.err[c]  = m_err[c];
    end
    exp_q.push_back(e);
  endtask

  task automatic idle();
    step(0, 2'b00, 0, 2'b00, 0, 0, 2'b00, 0, 0, 2'b00);
  endtask

  // Monitor: every falling edge that has a pending expectation is compared.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("credit_ch0", int'(credit[CW-1:0]),  int'(e.credit[CW-1:0]));
      check("credit_ch1", int'(credit[2*CW-1:CW]), int'(e.credit[2*CW-1:CW]));
      check("left", int'(left), int'(e.left));
      check("crit", int'(crit), int'(e.crit));
      check("full", int'(full), int'(e.full));
      check("err",  int'(err),  int'(e.err));
    end
  end

  initial begin
    rst = 1'b1; init = '0; cfg = '0; give = '0; give_amt = '0;
    take = '0; take_amt = '0; clr = '0;
    for (int c = 0; c < NCH; c++) begin m_cnt[c] = 0; m_err[c] = 1'b0; end

    // Reset to full.
    step(1, 2'b00, 0, 2'b00, 0, 0, 2'b00, 0, 0, 2'b00);
    idle();
    // ch0 drains 8->5->2->0.
    step(0, 2'b00, 0, 2'b00, 0, 0, 2'b01, 3, 0, 2'b00);
    step(0, 2'b00, 0, 2'b00, 0, 0, 2'b01, 3, 0, 2'b00);
    step(0, 2'b00, 0, 2'b00, 0, 0, 2'b01, 2, 0, 2'b00);
    // ch0 to 2, then give4+take1 -> 5, give 3 -> 8.
    step(0, 2'b00, 0, 2'b01, 2, 0, 2'b00, 0, 0, 2'b00);
    step(0, 2'b00, 0, 2'b01, 4, 0, 2'b01, 1, 0, 2'b00);
    step(0, 2'b00, 0, 2'b01, 3, 0, 2'b00, 0, 0, 2'b00);
    // Strobe with zero amount is a no-op.
    step(0, 2'b00, 0, 2'b11, 0, 0, 2'b11, 0, 0, 2'b00);
    // ch1 to 1, underflow, clear, then clear loses to an overflow.
    step(0, 2'b00, 0, 2'b00, 0, 0, 2'b10, 0, 4, 2'b00);
    step(0, 2'b00, 0, 2'b00, 0, 0, 2'b10, 0, 3, 2'b00);
    step(0, 2'b00, 0, 2'b00, 0, 0, 2'b10, 0, 3, 2'b00);
    step(0, 2'b00, 0, 2'b00, 0, 0, 2'b00, 0, 0, 2'b10);
    step(0, 2'b00, 0, 2'b10, 0, 4, 2'b00, 0, 0, 2'b00);
    step(0, 2'b00, 0, 2'b10, 0, 4, 2'b00, 0, 0, 2'b00);
    step(0, 2'b00, 0, 2'b10, 0, 2, 2'b00, 0, 0, 2'b10);
    // ch0 init with cfg 12 (clamped, strobes discarded), then cfg 3.
    step(0, 2'b00, 0, 2'b00, 0, 0, 2'b01, 4, 0, 2'b00);
    step(0, 2'b01, 12, 2'b01, 4, 0, 2'b01, 4, 0, 2'b00);
    step(0, 2'b01, 3, 2'b01, 4, 0, 2'b00, 0, 0, 2'b00);
    // Init while the error is set leaves it set.
    step(0, 2'b10, 5, 2'b10, 0, 4, 2'b00, 0, 0, 2'b00);
    // Reset overrides init/give/take in flight.
    step(1, 2'b11, 2, 2'b11, 4, 4, 2'b11, 3, 3, 2'b00);
    idle();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      bit r;
      bit [1:0] in;
      r  = ($urandom_range(59, 0) == 0);
      in = {($urandom_range(15, 0) == 0), ($urandom_range(15, 0) == 0)};
      step(r, in, int'($urandom_range(15, 0)),
           2'($urandom_range(3, 0)), int'($urandom_range(MXS, 0)), int'($urandom_range(MXS, 0)),
           2'($urandom_range(3, 0)), int'($urandom_range(MXS, 0)), int'($urandom_range(MXS, 0)),
           {($urandom_range(7, 0) == 0), ($urandom_range(7, 0) == 0)});
    end
    idle();

    repeat (3) @(negedge clk);
    #2;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
